// File: rtl/cache_pkg.sv
// Shared definitions for the data cache controller.
//   - FSM state encoding
//   - default geometry (NUM_LINES / INDEX_W)
//   - word-alignment constant (byte-offset bits dropped from addresses)
package cache_pkg;

    localparam int DEF_NUM_LINES = 16;
    localparam int DEF_INDEX_W   = 4;
    localparam int WORD_OFS_W    = 2;   // addr[1:0] selects a byte inside a word

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_BUS_RD,
        ST_BUS_WR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
// Ports:
//   clk, reset           - clock, async active-high reset (clears valid bits only)
//   flush                - clear every valid bit on the next edge; beats a same-cycle fill
//   rd_idx               - combinational read port index
//   rd_valid/rd_tag/rd_data - read port outputs
//   wr_en, wr_idx, wr_data  - write port; wr_en writes the data word
//   wr_fill, wr_tag      - with wr_en, also set valid and the tag (line fill)
module dcache_line_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int INDEX_W   = DEF_INDEX_W,
    parameter int TAG_W     = 32 - DEF_INDEX_W - WORD_OFS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic               wr_fill,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];
    logic [31:0]          data_d [NUM_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_idx] = wr_data;
            if (wr_fill) begin
                valid_d[wr_idx] = 1'b1;
                tag_d[wr_idx]   = wr_tag;
            end
        end
        // Flush wins over a fill in the same cycle: the line stays invalid.
        if (flush)
            valid_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // Tag/data need no reset: they are never consulted while the valid bit is clear.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// between a load/store queue and a single-beat backing-memory bus.
// Ports:
//   clk, reset            - clock, async active-high reset
//   mem_req/mem_we        - LSQ request and store flag, held until mem_ack
//   mem_addr/mem_data     - byte address and store data
//   mem_ack/mem_read_val  - one-cycle completion pulse and load result (0 for stores)
//   flush                 - invalidate all lines
//   bus_req/bus_we        - backing-memory request and write flag
//   bus_addr/bus_wdata    - word-aligned address and write data
//   bus_ack/bus_rdata     - backing transfer done and read data
// Optional build macro DATA_CACHE_STATS_EN adds saturating hit_count/miss_count
// outputs counting load hits/misses.
module data_cache_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int INDEX_W   = DEF_INDEX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ack,
    output logic [31:0] mem_read_val,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 32 - INDEX_W - WORD_OFS_W;

    state_e      state_q, state_d;
    logic [31:WORD_OFS_W] waddr_q, waddr_d;   // latched word address
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        store_hit_q, store_hit_d;
    logic        mem_ack_q, mem_ack_d;
    logic [31:0] mem_read_val_q, mem_read_val_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_data;
    logic               wr_en, wr_fill;
    logic [31:0]        wr_data;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    // Byte offset is irrelevant to a word cache.
    logic unused_byte_ofs;
    assign unused_byte_ofs = ^mem_addr[WORD_OFS_W-1:0];

    assign idx = waddr_q[INDEX_W+WORD_OFS_W-1:WORD_OFS_W];
    assign tag = waddr_q[31:INDEX_W+WORD_OFS_W];
    assign hit = rd_valid && (rd_tag == tag);

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_fill  (wr_fill),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (wr_data)
    );

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
`endif

    always_comb begin
        state_d        = state_q;
        waddr_d        = waddr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        store_hit_d    = store_hit_q;
        mem_ack_d      = 1'b0;
        mem_read_val_d = mem_read_val_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        wr_en          = 1'b0;
        wr_fill        = 1'b0;
        wr_data        = (state_q == ST_BUS_RD) ? bus_rdata : wdata_q;
`ifdef DATA_CACHE_STATS_EN
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    waddr_d = mem_addr[31:WORD_OFS_W];
                    we_d    = mem_we;
                    wdata_d = mem_data;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (we_q) begin
                    // Write-through; remember hit so only a resident line is updated.
                    store_hit_d = hit;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = {waddr_q, {WORD_OFS_W{1'b0}}};
                    bus_wdata_d = wdata_q;
                    state_d     = ST_BUS_WR;
                end else if (hit) begin
                    mem_ack_d      = 1'b1;
                    mem_read_val_d = rd_data;
                    state_d        = ST_DONE;
`ifdef DATA_CACHE_STATS_EN
                    if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
`endif
                end else begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = {waddr_q, {WORD_OFS_W{1'b0}}};
                    state_d    = ST_BUS_RD;
`ifdef DATA_CACHE_STATS_EN
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
`endif
                end
            end
            ST_BUS_RD: begin
                if (bus_ack) begin
                    wr_en          = 1'b1;
                    wr_fill        = 1'b1;
                    bus_req_d      = 1'b0;
                    mem_ack_d      = 1'b1;
                    mem_read_val_d = bus_rdata;
                    state_d        = ST_DONE;
                end
            end
            ST_BUS_WR: begin
                if (bus_ack) begin
                    wr_en          = store_hit_q;
                    bus_req_d      = 1'b0;
                    mem_ack_d      = 1'b1;
                    mem_read_val_d = 32'd0;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                // LSQ may still drive mem_req for the op just retired; ignore it.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            waddr_q        <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            store_hit_q    <= 1'b0;
            mem_ack_q      <= 1'b0;
            mem_read_val_q <= '0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
`ifdef DATA_CACHE_STATS_EN
            hit_count_q    <= '0;
            miss_count_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            store_hit_q    <= store_hit_d;
            mem_ack_q      <= mem_ack_d;
            mem_read_val_q <= mem_read_val_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
`ifdef DATA_CACHE_STATS_EN
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
`endif
        end
    end

    assign mem_ack      = mem_ack_q;
    assign mem_read_val = mem_read_val_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
`ifdef DATA_CACHE_STATS_EN
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: cold miss, hit, write-through store,
// conflict eviction, flush, held mem_req, reset during a bus read.
module tb_data_cache_ctrl;

    localparam int LAT = 3;   // bus_ack is driven on the LAT-th cycle bus_req is seen

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_data = '0;
    logic        mem_ack;
    logic [31:0] mem_read_val;
    logic        flush = 1'b0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'hBAD0BAD0;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] bus_we_s, bus_addr_s, bus_wdata_s;
    bit          bus_unstable;

    always #5 clk = ~clk;

    data_cache_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack),
        .mem_read_val (mem_read_val),
        .flush        (flush),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, act as the bus slave, return latency (cycles from the first
    // mem_req edge to the mem_ack cycle), number of bus requests and load value.
    task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input bit hold,
                          output int cyc, output int nbus, output logic [31:0] rval);
        int  bcnt = 0;
        bit  prev = 0;
        bit  got  = 0;
        cyc = 0; nbus = 0; rval = 'x; bus_unstable = 0;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_data = wd;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus_ack   = 1'b0;
            bus_rdata = 32'hBAD0BAD0;
            if (bus_req) begin
                if (!prev) begin
                    nbus++;
                    bus_we_s = {31'd0, bus_we}; bus_addr_s = bus_addr; bus_wdata_s = bus_wdata;
                end else if ({31'd0, bus_we} !== bus_we_s || bus_addr !== bus_addr_s ||
                             bus_wdata !== bus_wdata_s)
                    bus_unstable = 1;
                bcnt++;
                if (bcnt == LAT) begin bus_ack = 1'b1; bus_rdata = rd; end
            end
            prev = bus_req;
            if (mem_ack) begin got = 1; rval = mem_read_val; end
        end
        bus_ack = 1'b0;
        if (!got) chk("op_timeout", 32'd0, 32'd1);
        if (hold) begin @(posedge clk); #1; end
        mem_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    initial begin
        int          cyc, nbus, acks, breqs;
        logic [31:0] rv;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
        chk("rst_read_val", mem_read_val, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold load miss
        run_op(1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0, cyc, nbus, rv);
        chk("cold_lat", cyc, 2 + LAT);
        chk("cold_nbus", nbus, 1);
        chk("cold_bus_we", bus_we_s, 32'd0);
        chk("cold_bus_addr", bus_addr_s, 32'h100);
        chk("cold_stable", {31'd0, bus_unstable}, 32'd0);
        chk("cold_val", rv, 32'hDEADBEEF);

        // Repeat load hits (byte offset ignored)
        run_op(1'b0, 32'h103, 32'd0, 32'h0, 0, cyc, nbus, rv);
        chk("hit_lat", cyc, 2);
        chk("hit_nbus", nbus, 0);
        chk("hit_val", rv, 32'hDEADBEEF);
`ifdef DATA_CACHE_STATS_EN
        chk("hit_cnt1", hit_count, 32'd1);
        chk("miss_cnt1", miss_count, 32'd1);
`endif

        // Store: write-through, hit updates line
        run_op(1'b1, 32'h100, 32'h12345678, 32'h0, 0, cyc, nbus, rv);
        chk("st_nbus", nbus, 1);
        chk("st_bus_we", bus_we_s, 32'd1);
        chk("st_bus_addr", bus_addr_s, 32'h100);
        chk("st_bus_wdata", bus_wdata_s, 32'h12345678);
        chk("st_stable", {31'd0, bus_unstable}, 32'd0);
        chk("st_val", rv, 32'd0);
        run_op(1'b0, 32'h100, 32'd0, 32'h0, 0, cyc, nbus, rv);
        chk("st_hit_lat", cyc, 2);
        chk("st_hit_val", rv, 32'h12345678);

        // Store miss to unfilled line: no allocate
        run_op(1'b1, 32'h10C, 32'h0BADF00D, 32'h0, 0, cyc, nbus, rv);
        run_op(1'b0, 32'h10C, 32'd0, 32'h5555010C, 0, cyc, nbus, rv);
        chk("nwa_nbus", nbus, 1);
        chk("nwa_val", rv, 32'h5555010C);

        // Conflict: 0x140 shares index 0 with 0x100
        run_op(1'b0, 32'h140, 32'd0, 32'hAAAA0140, 0, cyc, nbus, rv);
        chk("cf1_nbus", nbus, 1);
        chk("cf1_val", rv, 32'hAAAA0140);
        run_op(1'b0, 32'h100, 32'd0, 32'h11110100, 0, cyc, nbus, rv);
        chk("cf2_nbus", nbus, 1);
        chk("cf2_val", rv, 32'h11110100);

        // Flush after fill of 0x200
        run_op(1'b0, 32'h200, 32'd0, 32'h22220200, 0, cyc, nbus, rv);
        run_op(1'b0, 32'h200, 32'd0, 32'h0, 0, cyc, nbus, rv);
        chk("pre_fl_hit", cyc, 2);
        do_flush();
        run_op(1'b0, 32'h200, 32'd0, 32'h33330200, 0, cyc, nbus, rv);
        chk("fl_nbus", nbus, 1);
        chk("fl_val", rv, 32'h33330200);
`ifdef DATA_CACHE_STATS_EN
        chk("hit_cnt2", hit_count, 32'd3);
        chk("miss_cnt2", miss_count, 32'd6);
`endif

        // mem_req held through DONE: one ack, no extra bus request
        run_op(1'b0, 32'h100, 32'd0, 32'h44440100, 1, cyc, nbus, rv);
        chk("hold_nbus", nbus, 1);
        chk("hold_val", rv, 32'h44440100);
        acks = 0; breqs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_ack) acks++;
            if (bus_req) breqs++;
        end
        chk("hold_extra_ack", acks, 0);
        chk("hold_extra_breq", breqs, 0);
        run_op(1'b0, 32'h100, 32'd0, 32'h0, 0, cyc, nbus, rv);
        chk("hold_hit_lat", cyc, 2);

        // Reset while in BUS_RD
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h108;
        cyc = 0;
        while (!bus_req && cyc < 10) begin @(negedge clk); cyc++; end
        chk("rbr_reached", {31'd0, bus_req}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("rbr_bus_req", {31'd0, bus_req}, 32'd0);
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ack) acks++;
        end
        chk("rbr_no_ack", acks, 0);
        run_op(1'b0, 32'h100, 32'd0, 32'h66660100, 0, cyc, nbus, rv);
        chk("rbr_miss_nbus", nbus, 1);
        chk("rbr_miss_val", rv, 32'h66660100);
`ifdef DATA_CACHE_STATS_EN
        chk("hit_cnt3", hit_count, 32'd0);
        chk("miss_cnt3", miss_count, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
